// File: rtl/gfx_text_pkg.sv
// Shared definitions for the text rendering path: control codes, the string
// controller state encoding and the per-character dispatch rule.
package gfx_text_pkg;

    localparam logic [7:0] CH_NUL = 8'h00;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_SP  = 8'h20;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_START   = 4'd1,
        ST_FETCH   = 4'd2,
        ST_DECODE  = 4'd3,
        ST_ISSUE   = 4'd4,
        ST_WAIT    = 4'd5,
        ST_ADVANCE = 4'd6,
        ST_NEWLINE = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

    // Where a freshly read character sends the controller: terminator ends the
    // string, LF starts a new line, a skippable space only moves the pen and
    // everything else is handed to the glyph drawer.
    function automatic state_t decode_next(input logic [7:0] ch, input logic skip_sp);
        state_t nxt;
        if (ch == CH_NUL) begin
            nxt = ST_DONE;
        end else if (ch == CH_LF) begin
            nxt = ST_NEWLINE;
        end else if (skip_sp && (ch == CH_SP)) begin
            nxt = ST_ADVANCE;
        end else begin
            nxt = ST_ISSUE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/text_buf.sv
// Character string storage: one write port, one read port with a single
// registered read stage so it maps onto block or distributed RAM.
module text_buf #(
    parameter int LEN = 32,
    parameter int AW  = $clog2(LEN)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem_r [LEN];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge clk) begin
        rd_data <= mem_r[rd_addr];
    end

endmodule

// File: rtl/draw_string.sv
// Text-line controller: walks the buffered string and drives a single-glyph
// drawer through start/done, tracking the pen on a character grid with
// newline, automatic wrap and early termination on NUL.
module draw_string
    import gfx_text_pkg::*;
#(
    parameter int CORDW      = 16,
    parameter int GLYPH_W    = 8,
    parameter int GLYPH_H    = 16,
    parameter int LEN        = 32,
    parameter int LINE_CHARS = 16,
    parameter int SKIP_SPACE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [$clog2(LEN)-1:0]  wr_addr,
    input  logic [7:0]              wr_data,
    input  logic                    start,
    input  logic [$clog2(LEN):0]    len,
    input  logic signed [CORDW-1:0] x0,
    input  logic signed [CORDW-1:0] y0,
    output logic                    char_start,
    output logic [7:0]              char_ucp,
    output logic signed [CORDW-1:0] char_cx,
    output logic signed [CORDW-1:0] char_cy,
    input  logic                    char_done,
    output logic                    busy,
    output logic                    done
);

    localparam int AW = $clog2(LEN);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(LINE_CHARS) + 1;

    state_t                  state_r;
    state_t                  state_s;
    logic [AW-1:0]           idx_r;
    logic [CW-1:0]           col_r;
    logic [LW-1:0]           len_r;
    logic signed [CORDW-1:0] x0_r;
    logic signed [CORDW-1:0] pen_x_r;
    logic signed [CORDW-1:0] pen_y_r;
    logic [7:0]              rd_data_s;
    logic                    last_s;
    logic [CW-1:0]           col_inc_s;
    logic                    wrap_s;

    // Writes from the CPU side are locked out while a render is walking the buffer.
    text_buf #(.LEN(LEN), .AW(AW)) u_buf (
        .clk     (clk),
        .wr_en   (wr_en && !busy),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx_r),
        .rd_data (rd_data_s)
    );

    // idx is widened before the compare so len-1 never underflows.
    assign last_s    = (({1'b0, idx_r} + LW'(1)) == len_r);
    assign col_inc_s = col_r + CW'(1);
    assign wrap_s    = (col_inc_s == CW'(LINE_CHARS));

    // Next-state selection for the render sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_START;
                else       state_s = ST_IDLE;
            end
            ST_START: begin
                if (len_r == LW'(0)) state_s = ST_DONE;
                else                 state_s = ST_FETCH;
            end
            ST_FETCH:  state_s = ST_DECODE;
            ST_DECODE: state_s = decode_next(rd_data_s, SKIP_SPACE != 0);
            ST_ISSUE:  state_s = ST_WAIT;
            ST_WAIT: begin
                if (char_done) state_s = ST_ADVANCE;
                else           state_s = ST_WAIT;
            end
            ST_ADVANCE, ST_NEWLINE: begin
                if (last_s) state_s = ST_DONE;
                else        state_s = ST_FETCH;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and registered handshake outputs, aligned with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            char_start <= 1'b0;
            char_ucp   <= 8'h00;
            char_cx    <= '0;
            char_cy    <= '0;
        end else begin
            state_r    <= state_s;
            busy       <= (state_s != ST_IDLE) && (state_s != ST_DONE);
            done       <= (state_s == ST_DONE);
            char_start <= (state_s == ST_ISSUE);
            if (state_s == ST_ISSUE) begin
                char_ucp <= rd_data_s;
                char_cx  <= pen_x_r;
                char_cy  <= pen_y_r;
            end
        end
    end

    // Render parameters, string index and pen/column tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r   <= '0;
            col_r   <= '0;
            len_r   <= '0;
            x0_r    <= '0;
            pen_x_r <= '0;
            pen_y_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        len_r   <= len;
                        x0_r    <= x0;
                        pen_x_r <= x0;
                        pen_y_r <= y0;
                        idx_r   <= '0;
                        col_r   <= '0;
                    end
                end
                ST_ADVANCE: begin
                    if (wrap_s) begin
                        col_r   <= '0;
                        pen_x_r <= x0_r;
                        pen_y_r <= pen_y_r + CORDW'(GLYPH_H);
                    end else begin
                        col_r   <= col_inc_s;
                        pen_x_r <= pen_x_r + CORDW'(GLYPH_W);
                    end
                    if (!last_s) idx_r <= idx_r + AW'(1);
                end
                ST_NEWLINE: begin
                    col_r   <= '0;
                    pen_x_r <= x0_r;
                    pen_y_r <= pen_y_r + CORDW'(GLYPH_H);
                    if (!last_s) idx_r <= idx_r + AW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_string.sv
// Bench for draw_string: a string-level reference model predicts every glyph
// request (cycle, code, position) and the done cycle, a mock glyph drawer
// answers with a programmable latency, and one process compares each cycle.
module tb_draw_string;

    localparam int LC = 4;
    localparam int GW = 8;
    localparam int GH = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               wr_en;
    logic [4:0]         wr_addr;
    logic [7:0]         wr_data;
    logic               start;
    logic [5:0]         len;
    logic signed [15:0] x0, y0;
    logic               char_start;
    logic [7:0]         char_ucp;
    logic signed [15:0] char_cx, char_cy;
    logic               char_done;
    logic               busy, done;

    draw_string #(.CORDW(16), .GLYPH_W(GW), .GLYPH_H(GH), .LEN(32),
                  .LINE_CHARS(LC), .SKIP_SPACE(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .len(len), .x0(x0), .y0(y0),
        .char_start(char_start), .char_ucp(char_ucp), .char_cx(char_cx), .char_cy(char_cy),
        .char_done(char_done), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                 cyc;
        logic [7:0]         ucp;
        logic signed [15:0] cx;
        logic signed [15:0] cy;
    } ev_t;

    ev_t        exp_q[$];
    int         done_cyc;
    int         s_cyc;
    bit         active = 0;
    bit         have_last = 0;
    logic [7:0] bmem [32];
    int         drv_d = 2;
    int         pend = 0;
    bit         spur = 0;
    bit         drawer_clr = 0;
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: what the string must produce, character by character.
    task automatic model_render(input int s, input int ln, input int sx, input int sy);
        int t, col;
        logic [7:0] c;
        logic signed [15:0] px, py;
        ev_t e;
        exp_q.delete();
        t = s + 1; col = 0; px = 16'(sx); py = 16'(sy); done_cyc = -1;
        if (ln == 0) done_cyc = s + 2;
        for (int i = 0; i < ln && done_cyc < 0; i++) begin
            c = bmem[i];
            if (c == 8'h00) begin
                done_cyc = t + 3;
            end else begin
                if (c == 8'h0A) begin
                    col = 0; px = 16'(sx); py = py + 16'(GH); t = t + 3;
                end else begin
                    if (c != 8'h20) begin
                        e.cyc = t + 3; e.ucp = c; e.cx = px; e.cy = py;
                        exp_q.push_back(e);
                        t = t + 3 + drv_d;
                    end else begin
                        t = t + 3;
                    end
                    col++; px = px + 16'(GW);
                    if (col == LC) begin col = 0; px = 16'(sx); py = py + 16'(GH); end
                end
                if (i == ln - 1) done_cyc = t + 1;
            end
        end
    endtask

    // Mock glyph drawer: char_done pulses drv_d cycles after each request.
    initial begin
        char_done = 1'b0;
        forever begin
            @(negedge clk);
            char_done = 1'b0;
            if (drawer_clr) begin
                pend = 0; drawer_clr = 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) char_done = 1'b1;
            end
            if (spur) begin char_done = 1'b1; spur = 0; end
            if (char_start) pend = drv_d - 1;
        end
    end

    // Cycle-by-cycle comparison against the model while a render is in flight.
    initial begin
        logic [7:0] last_ucp;
        logic signed [15:0] last_cx, last_cy;
        bit exp_cs;
        forever begin
            @(negedge clk);
            if (active) begin
                exp_cs = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
                chk("char_start", char_start, exp_cs);
                if (exp_cs) begin
                    chk("char_ucp", char_ucp, exp_q[0].ucp);
                    chk("char_cx", char_cx, exp_q[0].cx);
                    chk("char_cy", char_cy, exp_q[0].cy);
                    last_ucp = exp_q[0].ucp; last_cx = exp_q[0].cx; last_cy = exp_q[0].cy;
                    have_last = 1;
                    void'(exp_q.pop_front());
                end else if (have_last && (cyc % 3 == 0)) begin
                    chk("hold_ucp", char_ucp, last_ucp);
                    chk("hold_cxy", {char_cx, char_cy}, {last_cx, last_cy});
                end
                chk("done", done, cyc == done_cyc);
                chk("busy", busy, (cyc > s_cyc) && (cyc < done_cyc));
                if (cyc >= done_cyc) begin
                    chk("glyphs_left", exp_q.size(), 0);
                    active = 0;
                end
            end
        end
    end

    task automatic write_byte(input int a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'(a); wr_data = d; bmem[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write_str(input string s);
        for (int i = 0; i < s.len(); i++) write_byte(i, s[i]);
    endtask

    // One render; ps/pw/ra poke start, a locked-out write and reset at s+n (0 = off).
    task automatic do_render(input int ln, input int sx, input int sy,
                             input int ps, input int pw, input int ra);
        @(negedge clk);
        len = 6'(ln); x0 = 16'(sx); y0 = 16'(sy);
        s_cyc = cyc;
        model_render(s_cyc, ln, sx, sy);
        have_last = 0;
        start = 1'b1;
        active = 1;
        for (int n = 0; n < 3000 && active; n++) begin
            @(negedge clk);
            start   = (ps != 0) && (cyc == s_cyc + ps);
            wr_en   = (pw != 0) && (cyc == s_cyc + pw);
            wr_addr = 5'd0;
            wr_data = 8'h5A;
            if ((ra != 0) && (cyc == s_cyc + ra)) begin
                rst = 1'b1; active = 0; drawer_clr = 1;
            end
        end
        start = 1'b0; wr_en = 1'b0;
        if (active) begin
            chk("render_timeout", 32'd1, 32'd0);
            active = 0;
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 8'h00;
        start = 1'b0; len = 6'd0; x0 = 16'sd0; y0 = 16'sd0;
        for (int i = 0; i < 32; i++) bmem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_char_start", char_start, 1'b0);
        chk("rst_char_ucp", char_ucp, 8'h00);
        chk("rst_char_cxy", {char_cx, char_cy}, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;

        // Basic "AB" at (10,20), drawer latency 3.
        write_str("AB");
        drv_d = 3;
        model_render(0, 2, 10, 20);
        chk("pin_ab_n", exp_q.size(), 2);
        chk("pin_ab0", {exp_q[0].cyc[7:0], exp_q[0].ucp, exp_q[0].cx, exp_q[0].cy}, {8'd4, 8'h41, 16'd10, 16'd20});
        chk("pin_ab1", {exp_q[1].cyc[7:0], exp_q[1].ucp, exp_q[1].cx, exp_q[1].cy}, {8'd10, 8'h42, 16'd18, 16'd20});
        chk("pin_ab_done", done_cyc, 14);
        do_render(2, 10, 20, 0, 0, 0);

        // Newline "A\nB".
        write_str("A\nB");
        drv_d = 2;
        model_render(0, 3, 10, 20);
        chk("pin_nl_n", exp_q.size(), 2);
        chk("pin_nl_b", {exp_q[1].ucp, exp_q[1].cx, exp_q[1].cy}, {8'h42, 16'd10, 16'd36});
        do_render(3, 10, 20, 0, 0, 0);

        // Newline with negative x0 and y wrapping past +32767.
        do_render(3, -4, 32760, 0, 0, 0);

        // Wrap after LC=4 characters.
        write_str("ABCDEF");
        model_render(0, 6, 0, 0);
        chk("pin_wrap_e", {exp_q[4].ucp, exp_q[4].cx, exp_q[4].cy}, {8'h45, 16'd0, 16'd16});
        chk("pin_wrap_f", {exp_q[5].ucp, exp_q[5].cx, exp_q[5].cy}, {8'h46, 16'd8, 16'd16});
        do_render(6, 0, 0, 0, 0, 0);

        // Skipped space and early NUL termination.
        write_str("A B");
        write_byte(3, 8'h00);
        write_byte(4, 8'h43);
        model_render(0, 5, 0, 0);
        chk("pin_term_n", exp_q.size(), 2);
        chk("pin_term_b", {exp_q[1].ucp, exp_q[1].cx, exp_q[1].cy}, {8'h42, 16'd16, 16'd0});
        chk("pin_term_done", done_cyc, 17);
        do_render(5, 0, 0, 0, 0, 0);

        // len == 0.
        model_render(0, 0, 0, 0);
        chk("pin_len0_done", done_cyc, 2);
        do_render(0, 5, 5, 0, 0, 0);

        // start during WAIT and a write while busy are both ignored.
        write_str("XY");
        drv_d = 6;
        do_render(2, 100, 50, 6, 5, 0);
        drv_d = 2;
        do_render(2, 100, 50, 0, 0, 0);

        // Spurious char_done in IDLE.
        @(negedge clk);
        spur = 1;
        repeat (3) @(negedge clk);
        chk("spur_idle", {char_start, busy, done}, 3'b000);
        do_render(2, 1, 2, 0, 0, 0);

        // Reset during WAIT of the second glyph, then a clean re-render.
        write_str("ABC");
        drv_d = 5;
        do_render(3, 0, 0, 0, 0, 13);
        @(negedge clk);
        chk("rstmid_outs", {char_start, busy, done}, 3'b000);
        chk("rstmid_ucp", char_ucp, 8'h00);
        chk("rstmid_cxy", {char_cx, char_cy}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rstmid_quiet", {char_start, busy, done}, 3'b000);
        end
        drv_d = 2;
        do_render(3, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/draw_string.md
# draw_string

Text-line controller for the graphics library. It holds a short character string in an internal buffer. On a start request it walks the string and sequences an external single-glyph drawing engine through a start/busy/done handshake. It places each glyph on a character grid and handles newline, line wrap and early termination. It sits between CPU/test-pattern logic that writes text and the glyph drawer that feeds the framebuffer writer.

## Interface
Parameters:
- CORDW, 16, signed coordinate width
- GLYPH_W, 8, horizontal advance per character in pixels
- GLYPH_H, 16, vertical advance per line in pixels
- LEN, 32, string buffer depth in characters (power of two)
- LINE_CHARS, 16, characters per line before automatic wrap
- SKIP_SPACE, 1, when 1, 0x20 advances position without issuing a glyph

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- wr_en  in  1  buffer write strobe; ignored while busy
- wr_addr  in  $clog2(LEN)  buffer write index
- wr_data  in  8  character code (0-255)
- start  in  1  begin rendering; sampled only in IDLE
- len  in  $clog2(LEN)+1  characters to render, 0..LEN; latched at start
- x0, y0  in  signed CORDW  top-left of first character; latched at start
- char_start  out  1  one-cycle request to glyph drawer
- char_ucp  out  8  character code for the request
- char_cx, char_cy  out  signed CORDW  glyph position for the request
- char_done  in  1  glyph drawer completion pulse
- busy  out  1  string render in progress
- done  out  1  render complete, high for one cycle

## Operation
- The buffer is written only when wr_en is high and busy is low. Contents survive rst.
- FSM states:
  - IDLE: goes to START when start is high.
  - START: latches len, x0 and y0; clears idx and col; sets pen to (x0, y0); sets busy. Goes to DONE if len==0, otherwise to FETCH.
  - FETCH: presents idx to the buffer. The buffer has 1-cycle read latency. Goes to DECODE.
  - DECODE: acts on the character read.
    - 0x00 goes to DONE (terminates early).
    - 0x0A goes to NEWLINE.
    - 0x20 with SKIP_SPACE=1 goes to ADVANCE.
    - Any other code goes to ISSUE.
  - ISSUE: char_start=1. char_ucp, char_cx and char_cy are driven from the current character and pen. Goes to WAIT.
  - WAIT: stays until char_done, then goes to ADVANCE.
  - ADVANCE: applies the pen step and wrap rule (see Pen rules), then the last-character check.
  - NEWLINE: applies the newline pen update (see Pen rules), then the last-character check.
  - DONE: done=1 and busy=0. Goes to IDLE.
- Pen rules:
  - ADVANCE step: col+1 and pen.x+GLYPH_W.
  - Wrap: if col+1 == LINE_CHARS, col←0, pen.x←x0 and pen.y←pen.y+GLYPH_H.
  - NEWLINE: col←0, pen.x←x0, pen.y←pen.y+GLYPH_H.
- Last-character check (ADVANCE and NEWLINE): if idx==len-1, go to DONE; otherwise idx+1 and go to FETCH.
- Arithmetic:
  - Pen arithmetic is signed CORDW and wraps modulo 2^CORDW with no saturation.
  - idx is unsigned. idx==len-1 is evaluated with len widened to avoid underflow; len==0 never reaches this check.
- Interaction rules:
  - char_done is ignored outside WAIT.
  - start is ignored while busy.
  - char_ucp, char_cx and char_cy hold their last value outside ISSUE.

## Timing
- Reset values:
  - All outputs are 0: char_start, char_ucp, char_cx, char_cy, busy, done.
  - State is IDLE and internal counters are 0.
- rst mid-render: returns to IDLE the next cycle. char_start and busy go low with no done pulse. The glyph drawer must be reset alongside.
- start sampled at edge k:
  - busy is high from cycle k+1.
  - The first char_start is high in cycle k+4 (START, FETCH, DECODE, ISSUE).
- char_done sampled at edge m: the next char_start is in cycle m+4 (ADVANCE, FETCH, DECODE, ISSUE).
- Skipped space or newline: 3 cycles per character (FETCH, DECODE, ADVANCE/NEWLINE).
- Completion:
  - done is high in the cycle after the final ADVANCE or NEWLINE, or after DECODE of 0x00.
  - busy falls in the same cycle done rises.
  - A new start is accepted the cycle after done.
- len==0: done is high in cycle k+2.

## Structure
- Shared package gfx_text_pkg:
  - Control code constants CH_NUL=8'h00, CH_LF=8'h0A, CH_SP=8'h20.
  - FSM state enum.
- One sub-module, text_buf: LEN×8 simple dual-port synchronous RAM with one write port, one read port and 1-cycle registered read. It maps to block/distributed RAM.
- Estimated RTL: about 200 lines in total.

## Test plan
- Basic render: write "AB" and start with len=2 at (10,20). Required: char_start pulses with (0x41,10,20) then (0x42,18,20). The first pulse is 4 cycles after start. done is high 1 cycle after the ADVANCE that follows the second char_done.
- Newline: write "A\nB", len=3, at (10,20). Required: exactly 2 char_start pulses, with B at (10,36).
- Wrap: LINE_CHARS=4, "ABCDEF" at (0,0). Required: E at (0,16) and F at (8,16).
- Terminator and space: "A B\0C" with len=5 and SKIP_SPACE=1. Required: A at (0,0) and B at (16,0). C is never issued, and done follows DECODE of 0x00.
- Edge handshakes:
  - len=0: done in cycle k+2 with no char_start.
  - start during WAIT is ignored.
  - wr_en during busy leaves the buffer unchanged, confirmed by a second render.
  - A spurious char_done in IDLE causes no state change.
- Reset mid-render: assert rst during WAIT of the 2nd character. Required: all outputs are 0 the next cycle with no done pulse. A following start renders correctly from idx 0.
